fft_frame_uart_tx: RTL and testbench

Parametrised frame-streaming back end for the FFT core: captures one FFT output frame of up to N complex bins, buffers it, and serialises it over an 8N1 UART line as a framed byte stream. It replaces the fixed 32-bit, 16-point transmit path on the top-level tx_o pin and generalises it in sample width, frame length and line rate, adding short frames and an optional checksum.

---
 rtl/fft_frame_uart_tx.sv | 277 +++++++++++++++++++++++++++
 tb/tb_fft_frame_uart_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_uart_tx.sv
// fft_frame_uart_tx
//   Captures one FFT output frame of up to N complex bins into a local buffer
//   and sends it out on an 8N1 UART line as one framed byte stream:
//     0xA5, len-1, then for each bin the re bytes and then the im bytes
//     (MSB first), and optionally a checksum byte.
//   Optional build macro: CHECKSUM_EN. When it is defined, an XOR checksum of
//   the LEN byte and all data bytes is appended after the last data byte.
//
// Ports
//   clk         system clock, single domain
//   rst         synchronous active-high reset; aborts any frame in flight
//   in_valid    input sample valid
//   in_ready    block accepts a sample this cycle (LOAD, and the DONE cycle)
//   in_re       real part, two's complement
//   in_im       imaginary part, two's complement
//   in_last     marks the final sample of a frame (used only on a handshake)
//   tx_o        UART serial output, idle high
//   busy        high from the first header start-bit cycle to the last stop-bit cycle
//   frame_done  one-cycle pulse on the cycle after the last stop bit
module fft_frame_uart_tx #(
  parameter int BIT_WIDTH = 32,
  parameter int N         = 16,
  parameter int SIZE      = 4,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_re,
  input  logic [BIT_WIDTH-1:0] in_im,
  input  logic                 in_last,
  output logic                 tx_o,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CPB_RAW      = CLK_FREQ / BAUD;
  localparam int CLKS_PER_BIT = (CPB_RAW < 4) ? 4 : CPB_RAW;
  localparam int CLK_W        = $clog2(CLKS_PER_BIT);
  localparam int BPB          = BIT_WIDTH / 4;   // bytes per bin (re + im)
  localparam int IDX_W        = $clog2(BPB);
  localparam int WORD_W       = 2 * BIT_WIDTH;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_HDR  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
`ifdef CHECKSUM_EN
    ST_CHK  = 3'd4,
`endif
    ST_DONE = 3'd5
  } state_t;

`ifdef CHECKSUM_EN
  // Running checksum step: XOR-fold one byte into the accumulator.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  state_t              state_r;
  state_t              next_state_s;
  logic [WORD_W-1:0]   mem_r [N];
  logic [SIZE-1:0]     cnt_r;
  logic [SIZE-1:0]     len_m1_r;
  logic [SIZE-1:0]     rd_addr_r;
  logic [IDX_W-1:0]    byte_idx_r;
  logic                last_byte_r;
  logic [CLK_W-1:0]    clk_cnt_r;
  logic [3:0]          bit_cnt_r;
  logic [8:0]          shreg_r;
  logic                tx_r;
  logic                busy_r;
  logic                frame_done_r;
`ifdef CHECKSUM_EN
  logic [7:0]          chk_r;
`endif

  logic                in_ready_s;
  logic                tx_active_s;
  logic                hs_s;
  logic                load_end_s;
  logic                bit_end_s;
  logic                byte_end_s;
  logic                load_byte_s;
  logic                pop_data_s;
  logic [WORD_W-1:0]   rd_word_s;
  int                  data_shift_s;
  logic [7:0]          data_byte_s;
  logic [7:0]          next_byte_s;

  assign hs_s       = in_valid && in_ready_s;
  // A frame closes on in_last, or when the write fills the last buffer slot.
  assign load_end_s = hs_s && (in_last || (cnt_r == SIZE'(N - 1)));
  assign bit_end_s  = (clk_cnt_r == CLK_W'(CLKS_PER_BIT - 1));
  assign byte_end_s = bit_end_s && (bit_cnt_r == 4'd9);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_LOAD, ST_DONE: begin
        if (load_end_s) next_state_s = ST_HDR;
        else            next_state_s = ST_LOAD;
      end
      ST_HDR: begin
        if (byte_end_s) next_state_s = ST_LEN;
        else            next_state_s = ST_HDR;
      end
      ST_LEN: begin
        if (byte_end_s) next_state_s = ST_DATA;
        else            next_state_s = ST_LEN;
      end
      ST_DATA: begin
`ifdef CHECKSUM_EN
        if (byte_end_s && last_byte_r) next_state_s = ST_CHK;
        else                           next_state_s = ST_DATA;
`else
        if (byte_end_s && last_byte_r) next_state_s = ST_DONE;
        else                           next_state_s = ST_DATA;
`endif
      end
`ifdef CHECKSUM_EN
      ST_CHK: begin
        if (byte_end_s) next_state_s = ST_DONE;
        else            next_state_s = ST_CHK;
      end
`endif
      default: next_state_s = ST_LOAD;
    endcase
  end

  // State-decoded outputs and byte-load strobes. The DONE cycle already
  // accepts input so the next frame can start loading alongside frame_done.
  always_comb begin
    in_ready_s  = 1'b0;
    tx_active_s = 1'b0;
    case (state_r)
      ST_LOAD, ST_DONE: in_ready_s  = ~rst;
      ST_HDR, ST_LEN, ST_DATA: tx_active_s = 1'b1;
`ifdef CHECKSUM_EN
      ST_CHK: tx_active_s = 1'b1;
`endif
      default: begin
        in_ready_s  = 1'b0;
        tx_active_s = 1'b0;
      end
    endcase
    load_byte_s = load_end_s || (byte_end_s && tx_active_s && (next_state_s != ST_DONE));
    pop_data_s  = load_byte_s && (next_state_s == ST_DATA);
  end

  assign in_ready   = in_ready_s;
  assign tx_o       = tx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  // Select the next byte to put on the line; the buffer word comes from the
  // registered read address, so it is stable for the whole current byte.
  always_comb begin
    rd_word_s    = mem_r[rd_addr_r];
    data_shift_s = (BPB - 1 - int'(byte_idx_r)) * 8;
    data_byte_s  = 8'(rd_word_s >> data_shift_s);
    case (next_state_s)
      ST_HDR:  next_byte_s = 8'hA5;
      ST_LEN:  next_byte_s = 8'(len_m1_r);
      ST_DATA: next_byte_s = data_byte_s;
`ifdef CHECKSUM_EN
      ST_CHK:  next_byte_s = chk_r;
`endif
      default: next_byte_s = 8'hFF;
    endcase
  end

  // Frame buffer write port (no reset: contents are qualified by len).
  always_ff @(posedge clk) begin
    if (hs_s) begin
      mem_r[cnt_r] <= {in_re, in_im};
    end
  end

  // Load counter, read pointers, bit timing, shift register and line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= '0;
      len_m1_r     <= '0;
      rd_addr_r    <= '0;
      byte_idx_r   <= '0;
      last_byte_r  <= 1'b0;
      clk_cnt_r    <= '0;
      bit_cnt_r    <= 4'd0;
      shreg_r      <= 9'h1FF;
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef CHECKSUM_EN
      chk_r        <= 8'h00;
`endif
    end else begin
      busy_r       <= (next_state_s != ST_LOAD) && (next_state_s != ST_DONE);
      frame_done_r <= (next_state_s == ST_DONE);

      if (hs_s) begin
        if (load_end_s) cnt_r <= '0;
        else            cnt_r <= cnt_r + SIZE'(1);
      end else if (next_state_s == ST_DONE) begin
        cnt_r <= '0;
      end

      if (load_end_s) begin
        len_m1_r    <= cnt_r;
        rd_addr_r   <= '0;
        byte_idx_r  <= '0;
        last_byte_r <= 1'b0;
      end

      // A new byte starts with its start bit on the very next cycle, so
      // bytes follow each other without idle bits.
      if (load_byte_s) begin
        shreg_r   <= {1'b1, next_byte_s};
        tx_r      <= 1'b0;
        clk_cnt_r <= '0;
        bit_cnt_r <= 4'd0;
      end else if (tx_active_s) begin
        if (bit_end_s) begin
          clk_cnt_r <= '0;
          if (bit_cnt_r == 4'd9) begin
            tx_r      <= 1'b1;
            bit_cnt_r <= 4'd0;
          end else begin
            tx_r      <= shreg_r[0];
            shreg_r   <= {1'b1, shreg_r[8:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end else begin
          clk_cnt_r <= clk_cnt_r + CLK_W'(1);
        end
      end else begin
        tx_r      <= 1'b1;
        clk_cnt_r <= '0;
        bit_cnt_r <= 4'd0;
      end

      // Advance to the following data byte; flag the final one of the frame.
      if (pop_data_s) begin
        last_byte_r <= (rd_addr_r == len_m1_r) && (byte_idx_r == IDX_W'(BPB - 1));
        if (byte_idx_r == IDX_W'(BPB - 1)) begin
          byte_idx_r <= '0;
          rd_addr_r  <= rd_addr_r + SIZE'(1);
        end else begin
          byte_idx_r <= byte_idx_r + IDX_W'(1);
        end
      end

`ifdef CHECKSUM_EN
      if (load_byte_s && (next_state_s == ST_LEN)) begin
        chk_r <= next_byte_s;
      end else if (pop_data_s) begin
        chk_r <= chk_fold(chk_r, data_byte_s);
      end
`endif
    end
  end

endmodule

// File: tb/tb_fft_frame_uart_tx.sv
`timescale 1ns/1ps
module tb_fft_frame_uart_tx;

  localparam int BW  = 32;
  localparam int NB  = 16;
  localparam int SZ  = 4;
  localparam int CF  = 50_000_000;
  localparam int BD  = 5_000_000;
  localparam int CPB = CF / BD;
  localparam int BPS = BW / 8;
`ifdef CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_re;
  logic [BW-1:0] in_im;
  logic          in_last;
  logic          tx_o;
  logic          busy;
  logic          frame_done;

  fft_frame_uart_tx #(
    .BIT_WIDTH(BW), .N(NB), .SIZE(SZ), .CLK_FREQ(CF), .BAUD(BD)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .tx_o(tx_o), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]    rx_q[$];
  int            rx_t_q[$];
  int            fd_q[$];
  int            hs_q[$];
  int            overlap_cnt = 0;
  logic [7:0]    exp_q[$];
  logic [BW-1:0] s_re[64];
  logic [BW-1:0] s_im[64];
  logic          s_last[64];
  int            hs_last_cyc = 0;

  // UART receiver: finds the start edge, then samples every bit mid-cell.
  initial begin : uart_mon
    logic [7:0] b;
    int         t0;
    logic       ok;
    forever begin
      @(posedge clk); #1;
      if (rst === 1'b0 && tx_o === 1'b0) begin
        t0 = cyc;
        ok = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        if (tx_o !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(posedge clk);
          #1;
          b[k] = tx_o;
        end
        repeat (CPB) @(posedge clk);
        #1;
        if (tx_o !== 1'b1) ok = 1'b0;
        if (ok) begin
          rx_q.push_back(b);
          rx_t_q.push_back(t0);
        end
      end
    end
  end

  // Handshake / frame_done / overlap logger, sampled mid-cycle.
  initial begin : evt_mon
    forever begin
      @(negedge clk);
      if (in_valid === 1'b1 && in_ready === 1'b1) hs_q.push_back(cyc);
      if (frame_done === 1'b1) fd_q.push_back(cyc);
      if (busy === 1'b1 && in_ready === 1'b1) overlap_cnt++;
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    rx_q.delete(); rx_t_q.delete(); fd_q.delete(); hs_q.delete(); exp_q.delete();
    overlap_cnt = 0;
  endtask

  // Reference model: expected byte stream of one frame built from the samples.
  task automatic model_frame(input int first, input int len);
    logic [7:0]    c;
    logic [7:0]    bv;
    logic [BW-1:0] part;
    logic [BW-1:0] sh;
    exp_q.push_back(8'hA5);
    c = 8'(len - 1);
    exp_q.push_back(c);
    for (int s = first; s < first + len; s++) begin
      for (int p = 0; p < 2; p++) begin
        part = (p == 0) ? s_re[s] : s_im[s];
        for (int b = BPS - 1; b >= 0; b--) begin
          sh = part >> (8 * b);
          bv = sh[7:0];
          exp_q.push_back(bv);
          c = c ^ bv;
        end
      end
    end
    if (CHK_BYTES == 1) exp_q.push_back(c);
  endtask

  // Offer samples first..first+n-1 with in_valid held high throughout.
  task automatic offer(input int first, input int n);
    int i;
    int guard;
    i = first;
    guard = 0;
    while (i < first + n && guard < 40000) begin
      in_valid = 1'b1;
      in_re    = s_re[i];
      in_im    = s_im[i];
      in_last  = s_last[i];
      @(negedge clk);
      if (in_ready === 1'b1) begin
        i++;
        hs_last_cyc = cyc;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests_run++;
    assert (i == first + n) else begin
      tests_failed++;
      $error("FAIL offer_accepted observed=%0d expected=%0d", i - first, n);
    end
  endtask

  task automatic check_stream(input string tag);
    int guard;
    guard = 0;
    while (rx_q.size() < exp_q.size() && guard < 30000) begin
      @(posedge clk);
      guard++;
    end
    repeat (20 * CPB) @(posedge clk);
    #1;
    tests_run++;
    assert (rx_q.size() === exp_q.size()) else begin
      tests_failed++;
      $error("FAIL %s_bytecount observed=%0d expected=%0d", tag, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      tests_run++;
      assert (rx_q[i] === exp_q[i]) else begin
        tests_failed++;
        $error("FAIL %s_byte%0d observed=%02h expected=%02h", tag, i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin : main
    int n1;
    int n2;
    int guard;

    // Reset
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", int'(tx_o), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    clear_logs();

    // Full frame: re=k, im=-k
    for (int k = 0; k < NB; k++) begin
      s_re[k] = BW'(k);
      s_im[k] = BW'(-k);
      s_last[k] = (k == NB - 1);
    end
    model_frame(0, NB);
    offer(0, NB);
    chk("full_start_tx", int'(tx_o), 0);
    chk("full_start_busy", int'(busy), 1);
    chk("full_start_ready", int'(in_ready), 0);
    check_stream("full");
    chk("full_start_cycle", (rx_t_q.size() > 0) ? rx_t_q[0] : -1, hs_last_cyc + 1);
    chk("full_fd_count", fd_q.size(), 1);
    chk("full_fd_time", (fd_q.size() > 0 && rx_t_q.size() > 0) ? fd_q[0] - rx_t_q[0] : -1,
        (2 + NB * BW / 4 + CHK_BYTES) * 10 * CPB);
    chk("full_overlap", overlap_cnt, 0);
    clear_logs();

    // Short frame: 3 random samples
    for (int k = 0; k < 3; k++) begin
      s_re[k] = BW'($urandom);
      s_im[k] = BW'($urandom);
      s_last[k] = (k == 2);
    end
    model_frame(0, 3);
    offer(0, 3);
    check_stream("short");
    chk("short_fd_count", fd_q.size(), 1);
    chk("short_overlap", overlap_cnt, 0);
    clear_logs();

    // Backpressure: two frames with in_valid held high throughout
    n1 = $urandom_range(8, 2);
    n2 = $urandom_range(8, 1);
    for (int k = 0; k < n1 + n2; k++) begin
      s_re[k] = BW'($urandom);
      s_im[k] = BW'($urandom);
      s_last[k] = (k == n1 - 1) || (k == n1 + n2 - 1);
    end
    model_frame(0, n1);
    model_frame(n1, n2);
    offer(0, n1 + n2);
    check_stream("bp");
    chk("bp_hs_count", hs_q.size(), n1 + n2);
    chk("bp_fd_count", fd_q.size(), 2);
    chk("bp_resume_at_done", (hs_q.size() > n1 && fd_q.size() > 0) ? hs_q[n1] - fd_q[0] : -1, 0);
    chk("bp_overlap", overlap_cnt, 0);
    clear_logs();

    // Implicit end: 16 samples without in_last, 17th stalls until next LOAD
    for (int k = 0; k < NB + 1; k++) begin
      s_re[k] = BW'($urandom);
      s_im[k] = BW'($urandom);
      s_last[k] = (k == NB);
    end
    model_frame(0, NB);
    model_frame(NB, 1);
    offer(0, NB + 1);
    check_stream("impl");
    chk("impl_fd_count", fd_q.size(), 2);
    chk("impl_17th_at_done", (hs_q.size() > NB && fd_q.size() > 0) ? hs_q[NB] - fd_q[0] : -1, 0);
    clear_logs();

    // Reset during DATA byte 40, then a clean full frame
    for (int k = 0; k < NB; k++) begin
      s_re[k] = BW'($urandom);
      s_im[k] = BW'($urandom);
      s_last[k] = (k == NB - 1);
    end
    offer(0, NB);
    guard = 0;
    while (rx_q.size() < 40 && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    chk("mid_reached_byte40", int'(rx_q.size() >= 40), 1);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_tx", int'(tx_o), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", int'(in_ready), 1);
    repeat (300) @(posedge clk);
    #1;
    chk("mid_no_frame_done", fd_q.size(), 0);
    clear_logs();
    for (int k = 0; k < NB; k++) begin
      s_re[k] = BW'($urandom);
      s_im[k] = BW'($urandom);
      s_last[k] = (k == NB - 1);
    end
    model_frame(0, NB);
    offer(0, NB);
    check_stream("after_rst");
    chk("after_rst_fd_count", fd_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
